// File: rtl/pe_cmd_sequencer.sv
// pe_cmd_sequencer: instruction FIFO plus a repeat-expanding command FSM
// that feeds pe_array. Each operation is completed with a ready/ack handshake.
module pe_cmd_sequencer #(
    parameter int CMD_WIDTH    = 3,
    parameter int REPEAT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int INSTR_WIDTH  = REPEAT_WIDTH + CMD_WIDTH + 3
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [INSTR_WIDTH-1:0]        instr_data,
    input  logic                          flush,
    input  logic                          array_ready,
    output logic                          array_ack,
    output logic [CMD_WIDTH-1:0]          command_to_execute,
    output logic [1:0]                    shift_direction,
    output logic                          image_to_shift,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

    state_t                   state, state_d;
    logic [INSTR_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LW-1:0]            level, level_next;
    logic                     push, pop, load, head_ok;

    logic [CMD_WIDTH-1:0]     cmd_q, cmd_d, cmd_lat, cmd_lat_d;
    logic [1:0]               dir_q, dir_d;
    logic                     img_q, img_d;
    logic [REPEAT_WIDTH-1:0]  rep_left, rep_d;
    logic                     armed, armed_d;
    logic                     ack_q, ack_d, done_q, done_d, busy_q, busy_d, rdy_q;

    logic [INSTR_WIDTH-1:0]   head;
    logic [CMD_WIDTH-1:0]     head_cmd;
    logic [1:0]               head_dir;
    logic                     head_img;
    logic [REPEAT_WIDTH-1:0]  head_rep;

    assign head     = mem[rd_ptr];
    assign head_cmd = head[CMD_WIDTH-1:0];
    assign head_dir = head[CMD_WIDTH+1:CMD_WIDTH];
    assign head_img = head[CMD_WIDTH+2];
    assign head_rep = head[INSTR_WIDTH-1:CMD_WIDTH+3];

    // Registered ready already reflects fullness, so a full FIFO never takes a push.
    assign push       = instr_valid & rdy_q & ~flush;
    assign level_next = flush ? '0 : level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign head_ok    = (level != '0) && !flush;

    // Next-state and next-output decode; a head load overrides the per-state defaults.
    always_comb begin
        state_d   = state;
        cmd_d     = cmd_q;
        cmd_lat_d = cmd_lat;
        dir_d     = dir_q;
        img_d     = img_q;
        rep_d     = rep_left;
        armed_d   = armed;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cmd_d = '0;
                if (head_ok) begin
                    pop = 1'b1;
                    if (head_cmd != '0) load = 1'b1;
                end
            end
            RUN: begin
                // Only a ready seen low during this operation is trusted to rise again.
                if (!array_ready) armed_d = 1'b1;
                if (armed && array_ready) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    cmd_d   = '0;
                    armed_d = 1'b0;
                    done_d  = (rep_left == '0) || flush;
                end
            end
            ACK: begin
                armed_d = 1'b0;
                if (rep_left != '0 && !flush) begin
                    rep_d   = rep_left - 1'b1;
                    cmd_d   = cmd_lat;
                    state_d = RUN;
                end else if (head_ok && head_cmd != '0) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cmd_d     = head_cmd;
            cmd_lat_d = head_cmd;
            dir_d     = head_dir;
            img_d     = head_img;
            rep_d     = head_rep;
            armed_d   = 1'b0;
            state_d   = RUN;
        end
        if (flush) rep_d = '0;
        busy_d = (state_d != IDLE) || (level_next != '0);
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    // FIFO pointers, level and the registered output bank.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rdy_q    <= 1'b0;
            cmd_q    <= '0;
            cmd_lat  <= '0;
            dir_q    <= '0;
            img_q    <= 1'b0;
            rep_left <= '0;
            armed    <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_next;
            rdy_q    <= (level_next < DEPTH_L);
            cmd_q    <= cmd_d;
            cmd_lat  <= cmd_lat_d;
            dir_q    <= dir_d;
            img_q    <= img_d;
            rep_left <= rep_d;
            armed    <= armed_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= instr_data;
    end

    assign instr_ready        = rdy_q;
    assign array_ack          = ack_q;
    assign command_to_execute = cmd_q;
    assign shift_direction    = dir_q;
    assign image_to_shift     = img_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign fifo_level         = level;

endmodule
